// File: rtl/traffic_pkg.sv
// Shared lamp-state definitions for the highway and farm-way controllers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// The lamp encoding doubles as the FSM state encoding in both controllers,
// so a state register can drive its lamp output directly.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } light_t;

    // Width of the lamp/state field, kept here so both controllers agree.
    localparam int LIGHT_W = 2;

endpackage : traffic_pkg

// File: rtl/fw_timer.sv
// Saturating in-state cycle counter with synchronous clear.
// Latency: cnt reflects clr / increment one cycle after the edge that samples them.
// Backpressure: none; counts every cycle, holds at MAX until cleared.
//
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset, forces cnt to 0
//   clr   - synchronous clear, wins over increment
//   cnt   - current count, 0..MAX
module fw_timer #(
    parameter int MAX = 15,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] L_MAX = W'(MAX);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (r_cnt != L_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule : fw_timer

// File: rtl/fw_ctrl.sv
// Farm-way lamp controller: RED until handed over, then YELLOW, GREEN, hand back.
// Latency: state changes one edge after the triggering input; invk_hw is Mealy (same cycle).
// Backpressure: none; a request arriving outside RED is dropped and flagged in proto_err.
//
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   invk_fw   - one-cycle handover pulse from the highway controller
//   car_on_fw - farm-road vehicle sensor (level, synchronous)
//   invk_hw   - one-cycle handback pulse, high during the last GREEN cycle
//   light_fw  - lamp state (RED=0, GREEN=1, YELLOW=2), equal to the FSM state
//   timer_val - 0-based cycle index within the current state
//   proto_err - sticky flag: a request was seen while not in RED
//
// SHORT_CYCLES is expected not to exceed LONG_CYCLES+1: the shared timer
// saturates at LONG_CYCLES, so a longer YELLOW could never reach its last index.
module fw_ctrl
    import traffic_pkg::*;
#(
    parameter int SHORT_CYCLES = 3,
    parameter int MIN_GREEN    = 4,
    parameter int LONG_CYCLES  = 15,
    parameter int CNT_W        = $clog2(LONG_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             invk_fw,
    input  logic             car_on_fw,
    output logic             invk_hw,
    output logic [1:0]       light_fw,
    output logic [CNT_W-1:0] timer_val,
    output logic             proto_err
);

    // Last cycle index of each timed phase.
    localparam logic [CNT_W-1:0] L_SHORT_LAST = CNT_W'(SHORT_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_LONG_LAST  = CNT_W'(LONG_CYCLES - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_clr;
    logic             w_min_met;
    logic             w_green_exit;
    logic             w_invk_hw;
    logic             w_req_bad;
    logic             r_proto_err;

    // ------------------------------------------------------------------
    // In-state timer: cleared on any state change, including recovery
    // from an illegal encoding, so timer_val is always 0 on entry.
    // ------------------------------------------------------------------
    fw_timer #(
        .MAX (LONG_CYCLES),
        .W   (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_cnt_clr),
        .cnt   (w_cnt)
    );

    assign w_cnt_clr = (w_state_nxt != r_state);

    // ------------------------------------------------------------------
    // GREEN exit: forced at the long limit, or early once the minimum has
    // been served and the road is empty. A sensor dropout before the
    // minimum index is therefore harmless if the car reappears in time.
    // With MIN_GREEN==1 the minimum is met from the first GREEN cycle.
    // ------------------------------------------------------------------
    generate
        if (MIN_GREEN <= 1) begin : g_min_any
            assign w_min_met = 1'b1;
        end else begin : g_min_cmp
            localparam logic [CNT_W-1:0] L_MIN_LAST = CNT_W'(MIN_GREEN - 1);
            assign w_min_met = (w_cnt >= L_MIN_LAST);
        end
    endgenerate

    assign w_green_exit = (w_cnt == L_LONG_LAST) || (w_min_met && !car_on_fw);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and Mealy handback. invk_hw is only ever raised in
    // GREEN, so it drops with the asynchronous reset of r_state.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_invk_hw   = 1'b0;
        case (r_state)
            RED: begin
                if (invk_fw) begin
                    w_state_nxt = YELLOW;
                end
            end
            YELLOW: begin
                if (w_cnt == L_SHORT_LAST) begin
                    w_state_nxt = GREEN;
                end
            end
            GREEN: begin
                if (w_green_exit) begin
                    w_invk_hw   = 1'b1;
                    w_state_nxt = RED;
                end
            end
            default: begin
                w_state_nxt = RED;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Protocol error: a request while the farm road owns the intersection.
    // The request never reaches the FSM outside RED, so it is not queued,
    // including on the GREEN->RED edge itself.
    // ------------------------------------------------------------------
    assign w_req_bad = invk_fw && ((r_state == YELLOW) || (r_state == GREEN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_proto_err <= 1'b0;
        end else if (w_req_bad) begin
            r_proto_err <= 1'b1;
        end
    end

    assign invk_hw   = w_invk_hw;
    assign light_fw  = r_state;
    assign timer_val = w_cnt;
    assign proto_err = r_proto_err;

endmodule : fw_ctrl

// File: tb/tb_fw_ctrl.sv
// Directed self-checking bench for fw_ctrl: default parameters (DUT a) and
// the all-ones boundary parameters (DUT b), sharing clock and reset.
module tb_fw_ctrl;
    import traffic_pkg::*;

    logic       clk;
    logic       rst_n;

    logic       a_invk_fw, a_car, a_invk_hw, a_perr;
    logic [1:0] a_light;
    logic [3:0] a_timer;

    logic       b_invk_fw, b_car, b_invk_hw, b_perr;
    logic [1:0] b_light;
    logic [0:0] b_timer;

    int checks   = 0;
    int failures = 0;

    logic perr_a = 1'b0;
    logic perr_b = 1'b0;

    typedef struct packed {
        logic [1:0]  l;
        logic [31:0] t;
        logic        tchk;
        logic        h;
        logic        p;
    } exp_t;

    exp_t sb[$];

    fw_ctrl u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .invk_fw   (a_invk_fw),
        .car_on_fw (a_car),
        .invk_hw   (a_invk_hw),
        .light_fw  (a_light),
        .timer_val (a_timer),
        .proto_err (a_perr)
    );

    fw_ctrl #(
        .SHORT_CYCLES (1),
        .MIN_GREEN    (1),
        .LONG_CYCLES  (1)
    ) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .invk_fw   (b_invk_fw),
        .car_on_fw (b_car),
        .invk_hw   (b_invk_hw),
        .light_fw  (b_light),
        .timer_val (b_timer),
        .proto_err (b_perr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs, queue the expected outputs for this
    // cycle, then compare them away from the edge and advance.
    task automatic step(input bit sel, input logic fw, input logic car,
                        input logic [1:0] l, input int t, input logic h,
                        input logic p, input string tag);
        exp_t e;
        if (sel) begin
            b_invk_fw = fw;
            b_car     = car;
        end else begin
            a_invk_fw = fw;
            a_car     = car;
        end
        e.l    = l;
        e.t    = 32'(t);
        e.tchk = (t >= 0);
        e.h    = h;
        e.p    = p;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        chk({tag, "_light"}, 32'(sel ? b_light : a_light), 32'(e.l));
        chk({tag, "_invk_hw"}, 32'(sel ? b_invk_hw : a_invk_hw), 32'(e.h));
        chk({tag, "_proto_err"}, 32'(sel ? b_perr : a_perr), 32'(e.p));
        if (e.tchk) begin
            chk({tag, "_timer"}, sel ? 32'(b_timer) : 32'(a_timer), e.t);
        end
        @(posedge clk);
        #1;
    endtask

    // One full handover from RED and back. car_on_fw is high during GREEN
    // for indices below drop_at (except index glitch_at); viol_at is the
    // GREEN index carrying an illegal request (-1 for none).
    task automatic serve(input bit sel, input int short_c, input int min_g,
                         input int long_c, input int drop_at, input int glitch_at,
                         input int viol_at, input string tag);
        int   len;
        logic car;
        logic fw;
        logic p;
        p = sel ? perr_b : perr_a;
        if (drop_at <= min_g - 1)       len = min_g;
        else if (drop_at <= long_c - 1) len = drop_at + 1;
        else                            len = long_c;
        step(sel, 1'b1, 1'b1, RED, -1, 1'b0, p, {tag, "_req"});
        for (int y = 0; y < short_c; y++) begin
            step(sel, 1'b0, 1'b1, YELLOW, y, 1'b0, p, {tag, "_yel"});
        end
        for (int g = 0; g < len; g++) begin
            car = (g < drop_at) && (g != glitch_at);
            fw  = (g == viol_at);
            step(sel, fw, car, GREEN, g, (g == len - 1), p, {tag, "_grn"});
            if (fw) p = 1'b1;
        end
        step(sel, 1'b0, 1'b1, RED, 0, 1'b0, p, {tag, "_back"});
        step(sel, 1'b0, 1'b1, RED, 1, 1'b0, p, {tag, "_hold"});
        if (sel) perr_b = p;
        else     perr_a = p;
    endtask

    initial begin
        rst_n     = 1'b0;
        a_invk_fw = 1'b0;
        a_car     = 1'b0;
        b_invk_fw = 1'b0;
        b_car     = 1'b0;

        // Reset state, checked before any clock edge.
        #2;
        chk("rst_a_light", 32'(a_light), 32'(RED));
        chk("rst_a_timer", 32'(a_timer), 32'd0);
        chk("rst_a_invk_hw", 32'(a_invk_hw), 32'd0);
        chk("rst_a_proto_err", 32'(a_perr), 32'd0);
        chk("rst_b_light", 32'(b_light), 32'(RED));
        chk("rst_b_timer", 32'(b_timer), 32'd0);
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Car present throughout: 15 GREEN cycles.
        serve(1'b0, 3, 4, 15, 99, -1, -1, "full");
        // No car: MIN_GREEN cycles.
        serve(1'b0, 3, 4, 15, 0, -1, -1, "nocar");
        // Car leaves at index 8: 9 GREEN cycles.
        serve(1'b0, 3, 4, 15, 8, -1, -1, "leave8");
        // Sensor dropout before the minimum index has no effect.
        serve(1'b0, 3, 4, 15, 99, 1, -1, "glitch");
        // Violation at GREEN index 2: flagged, timing unchanged.
        serve(1'b0, 3, 4, 15, 99, -1, 2, "viol");
        // Request on the GREEN->RED edge: violation, not queued.
        serve(1'b0, 3, 4, 15, 0, -1, 3, "simul");

        // Reset mid-GREEN at timer_val=5.
        step(1'b0, 1'b1, 1'b1, RED, -1, 1'b0, perr_a, "mrst_req");
        for (int y = 0; y < 3; y++) begin
            step(1'b0, 1'b0, 1'b1, YELLOW, y, 1'b0, perr_a, "mrst_yel");
        end
        for (int g = 0; g < 5; g++) begin
            step(1'b0, 1'b0, 1'b1, GREEN, g, 1'b0, perr_a, "mrst_grn");
        end
        #1;
        chk("mrst_pre_timer", 32'(a_timer), 32'd5);
        chk("mrst_pre_light", 32'(a_light), 32'(GREEN));
        rst_n = 1'b0;
        #1;
        chk("mrst_light", 32'(a_light), 32'(RED));
        chk("mrst_timer", 32'(a_timer), 32'd0);
        chk("mrst_invk_hw", 32'(a_invk_hw), 32'd0);
        chk("mrst_proto_err", 32'(a_perr), 32'd0);
        perr_a = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, RED, -1, 1'b0, 1'b0, "post_rst");
        end

        // Boundary parameters 1/1/1, with and without a car.
        serve(1'b1, 1, 1, 1, 0, -1, -1, "bnd_nocar");
        serve(1'b1, 1, 1, 1, 99, -1, -1, "bnd_car");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fw_ctrl

// File: doc/fw_ctrl.md
Name: fw_ctrl

Overview:
Farm-way light controller. It is the peer of the highway controller in the two-road traffic intersection.
- Waits in RED until the highway side hands over with a one-cycle invk_fw pulse.
- Sequences YELLOW (prepare) then GREEN.
- Hands control back with a one-cycle invk_hw pulse once the farm road is served or times out.
- Owns its own cycle timer; no external timer block is needed.

Parameters:
SHORT_CYCLES, 3, YELLOW duration in clock cycles; must be >= 1.
MIN_GREEN, 4, minimum GREEN duration in cycles before an early exit is allowed; must be >= 1.
LONG_CYCLES, 15, maximum GREEN duration in cycles; must be >= MIN_GREEN.
CNT_W, $clog2(LONG_CYCLES+1), timer width. Derived; do not override.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous reset, active-low
invk_fw  in  1  handover request from the highway controller; one-cycle pulse
car_on_fw  in  1  farm-road vehicle sensor, level, synchronous to clk
invk_hw  out  1  handback to the highway controller; one-cycle pulse
light_fw  out  2  farm-road lamp state: RED=0, GREEN=1, YELLOW=2
timer_val  out  CNT_W  current in-state cycle count, for debug and verification
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset (rst_n=0, immediate, any state including mid-GREEN):
  - light_fw=RED, timer_val=0, proto_err=0.
  - invk_hw=0 combinationally.
- States RED, YELLOW, GREEN. State encoding equals light_fw. Any illegal encoding -> RED on the next edge.
- Timer:
  - Clears to 0 on every state change.
  - Otherwise increments each cycle, saturating at LONG_CYCLES.
  - timer_val always shows the cycle index within the current state (0-based).
- RED:
  - invk_fw=1 at an edge -> YELLOW.
  - Otherwise stays in RED; car_on_fw is ignored.
- YELLOW:
  - Lasts exactly SHORT_CYCLES cycles.
  - Transitions to GREEN at the edge where timer_val==SHORT_CYCLES-1.
- GREEN exit condition X = (timer_val==LONG_CYCLES-1) OR (timer_val>=MIN_GREEN-1 AND car_on_fw==0).
  - While in GREEN with X true: invk_hw=1, combinational (Mealy), and the next edge moves to RED.
  - Result: invk_hw is exactly one cycle wide, coincident with the last GREEN cycle. The highway controller samples it on that same edge.
  - invk_hw is 0 in every other state/cycle.
- GREEN length:
  - Car present throughout: exactly LONG_CYCLES cycles.
  - Car absent: exactly MIN_GREEN cycles.
  - Car drops at index k >= MIN_GREEN-1: exits at index k.
  - Car dropping then reasserting before MIN_GREEN-1 has no effect.
- Protocol violation:
  - invk_fw=1 sampled in YELLOW or GREEN sets proto_err=1 at that edge.
  - proto_err holds until reset.
  - The request is ignored; state and timer are unaffected.
- Simultaneous events:
  - invk_fw on the same edge as GREEN->RED is a violation: RED is entered and proto_err is set. The request is not queued.
- No internal queuing of requests. The highway controller must not re-request before it has seen invk_hw.

Decomposition:
- Shared package traffic_pkg holds the light-state constants RED=2'd0, GREEN=2'd1, YELLOW=2'd2, used by both the highway and farm-way controllers.
- One sub-module, fw_timer: saturating counter with sync clear, ports clk/rst_n/clr/cnt, parameter MAX.
- fw_ctrl holds the FSM, exit logic, invk_hw and proto_err.

Test Plan:
- Reset mid-GREEN: drive rst_n=0 at timer_val=5 -> light_fw=RED, timer_val=0, invk_hw=0, proto_err=0 without waiting for a clock edge; the block stays RED after release with no invk_fw.
- Full cycle, car_on_fw=1 held: invk_fw pulse sampled at edge E0 -> YELLOW after E0, GREEN after E3.
  - invk_hw=1 only between E17 and E18 (timer_val=14).
  - RED after E18.
- No car, car_on_fw=0: invk_fw at E0 -> GREEN after E3, invk_hw=1 only between E6 and E7 (timer_val=3), RED after E7.
- Car leaves mid-GREEN: car_on_fw 1->0 while timer_val=8 -> invk_hw rises combinationally in that same cycle, RED at the next edge, GREEN length 9 cycles.
- Violation: invk_fw pulse while in GREEN at timer_val=2 -> proto_err=1 after that edge and stays 1; the GREEN sequence and invk_hw timing are unchanged from the full-cycle case.
- Boundary parameters SHORT_CYCLES=1, MIN_GREEN=1, LONG_CYCLES=1: invk_fw at E0 -> YELLOW one cycle, GREEN one cycle with invk_hw=1, RED after E2.
